// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
//
// Multi-cycle multiply/divide sequencer that owns the HI/LO write path.
// MULTU/MULT use radix-2 shift-add, DIVU/DIV use restoring division, both
// over operand magnitudes with a final sign-fix cycle.
//
// Sequence: IDLE -> ITER (DW cycles) -> FIX -> DONE -> IDLE.
// A start sampled at edge N gives hilo_we/done during cycle N+DW+2.
//
// Handshake: start is a one-cycle request accepted only in IDLE (flush has
// priority). While busy, any start or hilo_rd raises stall so the requester
// holds. hilo_we/done pulse for the single DONE cycle, and hi/lo carry the
// result during that pulse.
//
// Optional build macro: MULDIV_FASTMUL_EN
//   When defined, MULT/MULTU go IDLE -> DONE and the product is formed
//   combinationally from the latched magnitudes. Divide is unchanged.
//
// Ports:
//   clk         pipeline clock
//   rst         asynchronous active-low reset
//   start       EX-stage mult/div request
//   op          00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   src_a       multiplicand / dividend
//   src_b       multiplier / divisor
//   flush       cancel in-flight operation
//   hilo_rd     ID stage holds MFHI/MFLO
//   busy        operation in flight (ITER, FIX, DONE)
//   stall       busy & (hilo_rd | start)
//   hilo_we     one-cycle HI/LO write strobe
//   done        completion pulse, same cycle as hilo_we
//   hi, lo      result (remainder / quotient for divide)
//   dbg_state_o current FSM state for debug/checkers
// ---------------------------------------------------------------------------
module muldiv_seq #(
   parameter int DW    = 32,
   parameter int CNT_W = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [DW-1:0] src_a,
   input  logic [DW-1:0] src_b,
   input  logic          flush,
   input  logic          hilo_rd,
   output logic          busy,
   output logic          stall,
   output logic          hilo_we,
   output logic          done,
   output logic [DW-1:0] hi,
   output logic [DW-1:0] lo,
   output logic [1:0]    dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ITER = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              is_div_q;
   logic              neg_res_q;   // product/quotient must be negated
   logic              neg_rem_q;   // remainder takes dividend's (negative) sign
   logic              div0_q;
   logic [DW-1:0]     opb_q;       // multiplicand (mul) or divisor (div)
   logic [2*DW-1:0]   acc_q;       // {hi,lo} product or {rem,quot}
   logic [DW-1:0]     hi_q;        // last committed HI
   logic [DW-1:0]     lo_q;        // last committed LO

   // ---- operand capture ----------------------------------------------------
   logic          op_signed;
   logic          sign_a;
   logic          sign_b;
   logic [DW-1:0] mag_a;
   logic [DW-1:0] mag_b;

   assign op_signed = op[0];
   assign sign_a    = op_signed & src_a[DW-1];
   assign sign_b    = op_signed & src_b[DW-1];
   assign mag_a     = sign_a ? (~src_a + 1'b1) : src_a;
   assign mag_b     = sign_b ? (~src_b + 1'b1) : src_b;

   // ---- multiply step: conditional add into upper half, then shift right ---
   logic [DW:0]     mul_sum;
   logic [2*DW-1:0] mul_step_d;

   assign mul_sum    = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opb_q} : '0);
   assign mul_step_d = {mul_sum, acc_q[DW-1:1]};

   // ---- divide step: shift {rem,quot} left, trial subtract -----------------
   // The shifted remainder needs DW+1 bits; when no borrow occurs the
   // difference is below the divisor, so DW bits of it are exact.
   logic [DW:0]     rem_sh;
   logic            div_borrow;
   logic [DW-1:0]   div_trial;
   logic [2*DW-1:0] div_step_d;

   assign rem_sh     = acc_q[2*DW-1:DW-1];
   assign div_borrow = rem_sh < {1'b0, opb_q};
   assign div_trial  = rem_sh[DW-1:0] - opb_q;
   assign div_step_d = div_borrow ? {rem_sh[DW-1:0], acc_q[DW-2:0], 1'b0}
                                  : {div_trial,      acc_q[DW-2:0], 1'b1};

   // ---- sign fix ------------------------------------------------------------
   // Divide by zero leaves quotient all ones and remainder equal to the
   // dividend magnitude; applying only the remainder sign restores src_a.
   logic [DW-1:0]   quot;
   logic [DW-1:0]   rem;
   logic [2*DW-1:0] fix_d;

   assign quot = acc_q[DW-1:0];
   assign rem  = acc_q[2*DW-1:DW];

   always_comb begin
      fix_d = acc_q;
      if (!is_div_q) begin
         fix_d = neg_res_q ? (~acc_q + 1'b1) : acc_q;
      end else begin
         fix_d[DW-1:0]    = (neg_res_q && !div0_q) ? (~quot + 1'b1) : quot;
         fix_d[2*DW-1:DW] = neg_rem_q ? (~rem + 1'b1) : rem;
      end
   end

   // ---- result presented in DONE -------------------------------------------
   logic [2*DW-1:0] res;

`ifdef MULDIV_FASTMUL_EN
   logic [2*DW-1:0] fast_prod;

   assign fast_prod = {{DW{1'b0}}, opb_q} * {{DW{1'b0}}, acc_q[DW-1:0]};
   assign res       = is_div_q ? acc_q : (neg_res_q ? (~fast_prod + 1'b1) : fast_prod);
`else
   assign res = acc_q;
`endif

   // ---- FSM + datapath ------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         opb_q     <= '0;
         acc_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !flush) begin
                  is_div_q  <= op[1];
                  neg_res_q <= sign_a ^ sign_b;
                  neg_rem_q <= sign_a;
                  div0_q    <= (src_b == '0);
                  cnt_q     <= CNT_W'(DW);
                  if (op[1]) begin
                     opb_q <= mag_b;
                     acc_q <= {{DW{1'b0}}, mag_a};
                  end else begin
                     opb_q <= mag_a;
                     acc_q <= {{DW{1'b0}}, mag_b};
                  end
`ifdef MULDIV_FASTMUL_EN
                  state_q <= op[1] ? S_ITER : S_DONE;
`else
                  state_q <= S_ITER;
`endif
               end
            end
            S_ITER: begin
               if (flush) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
               end else begin
                  acc_q <= is_div_q ? div_step_d : mul_step_d;
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) state_q <= S_FIX;
               end
            end
            S_FIX: begin
               if (flush) begin
                  state_q <= S_IDLE;
               end else begin
                  acc_q   <= fix_d;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               if (!flush) begin
                  hi_q <= res[2*DW-1:DW];
                  lo_q <= res[DW-1:0];
               end
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // ---- outputs -------------------------------------------------------------
   assign busy        = (state_q != S_IDLE);
   assign stall       = busy & (hilo_rd | start);
   assign hilo_we     = (state_q == S_DONE) & ~flush;
   assign done        = hilo_we;
   // hi/lo only show the new result while it is actually being written.
   assign hi          = hilo_we ? res[2*DW-1:DW] : hi_q;
   assign lo          = hilo_we ? res[DW-1:0]    : lo_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq: self-checking bench for muldiv_seq with an arithmetic
// reference model, directed corner cases and randomized operations.
// Cycle c of an operation is the clock period ending at edge N+c, where N is
// the edge that samples start.
// ---------------------------------------------------------------------------
module tb_muldiv_seq;

  localparam int DW = 32;

  // ---- clock / reset -------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [DW-1:0] src_a = '0;
  logic [DW-1:0] src_b = '0;
  logic          flush = 1'b0;
  logic          hilo_rd = 1'b0;
  logic          busy;
  logic          stall;
  logic          hilo_we;
  logic          done;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  muldiv_seq #(.DW(DW), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .hilo_rd(hilo_rd), .busy(busy), .stall(stall),
    .hilo_we(hilo_we), .done(done), .hi(hi), .lo(lo), .dbg_state_o(dbg_state)
  );

  // ---- scoreboard ----------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_hilo = 64'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    int          ia;
    int          ib;
    logic [63:0] r;
    case (o)
      2'b00: r = {32'b0, a} * {32'b0, b};
      2'b01: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 64'(sa * sb);
      end
      2'b10: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else begin
          ia = $signed(a);
          ib = $signed(b);
          r  = {32'(ia % ib), 32'(ia / ib)};
        end
      end
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [1:0] o);
`ifdef MULDIV_FASTMUL_EN
    if (!o[1]) return 1;
`endif
    return DW + 2;
  endfunction

  // ---- driver tasks --------------------------------------------------------
  // All tasks begin and end 1 time unit after a rising edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int          lat;
    bit          fin;
    logic [63:0] e;
    lat = 0;
    fin = 1'b0;
    exp_q.push_back(ref_model(o, a, b));
    issue(o, a, b);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (lat == 0 && hilo_we) begin
        lat = c;
        e = exp_q.pop_front();
        check({tag, "_hilo"}, {hi, lo}, e);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(exp_latency(o)));
        last_hilo = e;
      end else if (lat != 0) begin
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        fin = 1'b1;
      end
      @(posedge clk); #1;
      if (fin) break;
    end
    if (lat == 0) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---- stimulus ------------------------------------------------------------
  initial begin
    int bad;
    logic [63:0] prior;

    // reset state, with requests held active to show they are masked
    start = 1'b1; hilo_rd = 1'b1;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_hilo_we", 64'(hilo_we), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'h0);
    start = 1'b0; hilo_rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // directed operations
    run_op(2'b00, 32'hFFFF_FFFF, 32'd2,          "multu_max_x2");
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5,          "mult_neg3_x5");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2,          "div_neg7_by2");
    run_op(2'b10, 32'd100,       32'd0,          "divu_by0");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd0,          "div_neg_by0");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF,  "div_ovf");
    run_op(2'b11, 32'd7,         32'hFFFF_FFFE,  "div_7_byneg2");

    // hilo_rd stall window
    issue(2'b10, 32'd100, 32'd7);
    bad = 0;
    for (int c = 1; c <= 35; c++) begin
      hilo_rd = (c >= 2);
      @(negedge clk);
      if (c >= 2 && c <= 34 && stall !== 1'b1) bad++;
      if (c == 34) begin
        check("rd_hilo_we", 64'(hilo_we), 64'd1);
        check("rd_hilo", {hi, lo}, {32'd2, 32'd14});
      end
      if (c == 35) check("rd_stall_end", 64'(stall), 64'd0);
      @(posedge clk); #1;
    end
    hilo_rd = 1'b0;
    check("rd_stall_window", 64'(bad), 64'd0);
    last_hilo = {32'd2, 32'd14};

    // start while busy is ignored
    issue(2'b10, 32'd1000, 32'd3);
    bad = 0;
    for (int c = 1; c <= 36; c++) begin
      if (c == 5) begin
        op = 2'b00; src_a = 32'd55; src_b = 32'd5; start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
      if (c == 5) check("busy_start_stall", 64'(stall), 64'd1);
      if (c != 34 && hilo_we) bad++;
      if (c == 34) check("busy_start_hilo", {hilo_we, hi, lo}, {1'b1, 32'd1, 32'd333});
      if (c >= 35) check("busy_start_idle", 64'(busy), 64'd0);
      @(posedge clk); #1;
    end
    check("busy_start_no_extra_we", 64'(bad), 64'd0);
    last_hilo = {32'd1, 32'd333};

    // flush mid-ITER
    prior = last_hilo;
    issue(2'b10, 32'd12345, 32'd17);
    bad = 0;
    for (int c = 1; c <= 11; c++) begin
      flush = (c == 10);
      @(negedge clk);
      if (hilo_we) bad++;
      if (c == 11) begin
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hold", {hi, lo}, prior);
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;
    check("flush_no_we", 64'(bad), 64'd0);
    run_op(2'b00, 32'd1234, 32'd5678, "after_flush");

    // flush and start in the same IDLE cycle
    prior = last_hilo;
    op = 2'b10; src_a = 32'd9; src_b = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", 64'(busy), 64'd0);
    check("flush_start_hold", {hi, lo}, prior);
    @(posedge clk); #1;

    // flush during DONE
    prior = last_hilo;
    issue(2'b11, 32'hFFFF_FF00, 32'd7);
    for (int c = 1; c <= DW + 3; c++) begin
      flush = (c == DW + 2);
      @(negedge clk);
      if (c == DW + 2) begin
        check("flush_done_we", 64'(hilo_we), 64'd0);
        check("flush_done_hold", {hi, lo}, prior);
      end
      if (c == DW + 3) begin
        check("flush_done_busy", 64'(busy), 64'd0);
        check("flush_done_after", {hi, lo}, prior);
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;

    // asynchronous reset mid-ITER
    issue(2'b10, 32'd5000, 32'd9);
    hilo_rd = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_stall", 64'(stall), 64'd0);
    check("arst_hilo_we", 64'(hilo_we), 64'd0);
    check("arst_hilo", {hi, lo}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b1; hilo_rd = 1'b0;
    last_hilo = 64'h0;
    bad = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (hilo_we || done || busy) bad++;
      @(posedge clk); #1;
    end
    check("arst_no_done", 64'(bad), 64'd0);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---- global time bound ---------------------------------------------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
